// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
//   Shared definitions for the PISO framing stage: FSM state encoding, the
//   line levels used for start/stop/idle, and a counter-width helper.
//   The encodings and levels are shared with the downstream frame checker.
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
//   Parallel word handshake into the serializer.
//   in_data   WIDTH-bit word offered by the source
//   in_valid  source has a word on in_data
//   in_ready  serializer can take a word this cycle
//   master: word source; slave: serializer.
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/piso_serializer_bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
//   Bit-period divider. While en is high, div_cnt counts 0..CLKS_PER_BIT-1 and
//   tick is high in the last clock of each bit period. With CLKS_PER_BIT=1 the
//   tick is high on every enabled cycle.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears div_cnt
//   en    count enable (the serializer's busy flag)
//   tick  one-cycle pulse at the end of each bit period
// -----------------------------------------------------------------------------
module bit_tick_gen
  import piso_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              DIV_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt_r;

  // Divider counter: wraps at the end of each bit period, holds when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (en) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_ONE;
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  // The tick is internal to the serializer; its outputs are registered from it.
  assign tick = en & (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in/serial-out framing stage. Each accepted word is sent on s_out
//   as: start bit (1), WIDTH data bits LSB first, stop bit (0), each bit held
//   for CLKS_PER_BIT clocks. The line idles low.
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   bus    word handshake (in_data, in_valid, in_ready), slave side
//   s_out  serial line to the downstream shift stage (registered)
//   busy   frame in progress (registered)
//   done   one-cycle pulse when the stop bit completes (registered)
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  piso_serializer_if.slave     bus,
  output logic                 s_out,
  output logic                 busy,
  output logic                 done
);

  localparam int               BIT_W    = cnt_width(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  state_e             state_r,    state_s;
  logic [WIDTH-1:0]   shreg_r,    shreg_s;
  logic [BIT_W-1:0]   bit_cnt_r,  bit_cnt_s;
  logic               s_out_r,    s_out_s;
  logic               busy_r,     busy_s;
  logic               done_r,     done_s;
  logic               in_ready_r, in_ready_s;
  logic               tick_s;
  logic               accept_s;

  bit_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_r),
    .tick (tick_s)
  );

  assign accept_s = bus.in_valid & in_ready_r;

  // Next-state and next-output logic; s_out is computed one cycle ahead so the
  // line is driven straight from a flop.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    bit_cnt_s  = bit_cnt_r;
    s_out_s    = s_out_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    in_ready_s = in_ready_r;

    case (state_r)
      ST_IDLE: begin
        s_out_s = IDLE_LVL;
        busy_s  = 1'b0;
        if (accept_s) begin
          state_s    = ST_START;
          shreg_s    = bus.in_data;
          bit_cnt_s  = '0;
          s_out_s    = START_LVL;
          busy_s     = 1'b1;
          in_ready_s = 1'b0;
        end else begin
          // Also raises in_ready on the first cycle after reset.
          in_ready_s = 1'b1;
        end
      end

      ST_START: begin
        if (tick_s) begin
          state_s = ST_DATA;
          s_out_s = shreg_r[0];
        end else begin
          s_out_s = START_LVL;
        end
      end

      ST_DATA: begin
        if (tick_s) begin
          if (bit_cnt_r == BIT_LAST) begin
            state_s   = ST_STOP;
            s_out_s   = STOP_LVL;
            bit_cnt_s = '0;
          end else begin
            // Present the next bit now; the shift makes it shreg[0] afterwards.
            shreg_s   = shreg_r >> 1;
            bit_cnt_s = bit_cnt_r + BIT_ONE;
            s_out_s   = shreg_r[1];
          end
        end else begin
          s_out_s = s_out_r;
        end
      end

      ST_STOP: begin
        if (tick_s) begin
          state_s    = ST_IDLE;
          s_out_s    = IDLE_LVL;
          done_s     = 1'b1;
          in_ready_s = 1'b1;
          busy_s     = 1'b0;
        end else begin
          s_out_s = STOP_LVL;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        s_out_s    = IDLE_LVL;
        busy_s     = 1'b0;
        in_ready_s = 1'b0;
        bit_cnt_s  = '0;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      bit_cnt_r  <= '0;
      s_out_r    <= IDLE_LVL;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      bit_cnt_r  <= bit_cnt_s;
      s_out_r    <= s_out_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      in_ready_r <= in_ready_s;
    end
  end

  assign s_out        = s_out_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign bus.in_ready = in_ready_r;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Three serializer instances: #0 WIDTH=8/CLKS=1, #1 WIDTH=8/CLKS=4,
//   #2 WIDTH=4/CLKS=1 feeding a 4-bit SISO shift register.
//   A frame-level model predicts every output on every cycle; directed
//   sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_v [NI];
  logic [NI-1:0] valid_v;
  wire  [NI-1:0] so_w, busy_w, done_w, rdy_w;
  logic       chk_en = 1'b0;
  logic [3:0] siso;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) if0 ();
  piso_serializer_if #(.WIDTH(8)) if1 ();
  piso_serializer_if #(.WIDTH(4)) if2 ();

  assign if0.in_data  = data_v[0];
  assign if0.in_valid = valid_v[0];
  assign rdy_w[0]     = if0.in_ready;
  assign if1.in_data  = data_v[1];
  assign if1.in_valid = valid_v[1];
  assign rdy_w[1]     = if1.in_ready;
  assign if2.in_data  = data_v[2][3:0];
  assign if2.in_valid = valid_v[2];
  assign rdy_w[2]     = if2.in_ready;

  piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .s_out(so_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .s_out(so_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) dut2 (
    .clk(clk), .rst(rst), .bus(if2), .s_out(so_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  // Downstream 4-bit SISO chain: new bit enters at the MSB, shifts right.
  always @(posedge clk) begin
    if (rst) siso <= 4'b0000;
    else     siso <= {so_w[2], siso[3:1]};
  end

  function automatic int w_of(input int i);
    return (i == 2) ? 4 : 8;
  endfunction

  function automatic int c_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  // Line level k cycles into a frame: start, data LSB first, stop.
  function automatic logic exp_bit(input int w, input int c, input int k, input logic [7:0] word);
    int idx;
    idx = k / c;
    if (idx == 0)      return 1'b1;
    else if (idx <= w) return word[idx-1];
    else               return 1'b0;
  endfunction

  // ---------------- frame-level model ----------------
  logic       m_act  [NI];
  logic       m_rdy  [NI];
  logic       m_done [NI];
  int         m_k    [NI];
  logic [7:0] m_word [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      m_done[i] <= 1'b0;
      if (rst) begin
        m_act[i] <= 1'b0;
        m_rdy[i] <= 1'b0;
        m_k[i]   <= 0;
      end else if (m_act[i]) begin
        if (m_k[i] + 1 == (w_of(i) + 2) * c_of(i)) begin
          m_act[i]  <= 1'b0;
          m_done[i] <= 1'b1;
          m_rdy[i]  <= 1'b1;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end else if (m_rdy[i] && valid_v[i]) begin
        m_act[i]  <= 1'b1;
        m_k[i]    <= 0;
        m_word[i] <= data_v[i];
        m_rdy[i]  <= 1'b0;
      end else begin
        m_rdy[i] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("s_out%0d", i), 32'(so_w[i]),
            32'(m_act[i] ? exp_bit(w_of(i), c_of(i), m_k[i], m_word[i]) : 1'b0));
        chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_act[i]));
        chk($sformatf("done%0d", i), 32'(done_w[i]), 32'(m_done[i]));
        chk($sformatf("in_ready%0d", i), 32'(rdy_w[i]), 32'(m_rdy[i]));
      end
    end
  end

  // Call at a negedge; returns right after the accepting posedge.
  task automatic send(input int i, input logic [7:0] word, output time t_acc);
    bit got;
    got   = 1'b0;
    t_acc = 0;
    data_v[i]  = word;
    valid_v[i] = 1'b1;
    for (int n = 0; n < 60 && !got; n++) begin
      if (rdy_w[i]) begin
        @(posedge clk);
        t_acc = $time;
        got   = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time        t1, t2;
    logic [9:0] seq;
    logic [9:0] fr;
    int         cnt;
    bit         got2;

    valid_v   = 3'b001;
    data_v[0] = 8'hA5;
    data_v[1] = 8'h00;
    data_v[2] = 8'h00;
    fr        = 10'd0;

    // 1. reset held 3 cycles with in_valid high
    @(posedge clk);
    #1 chk_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("rst_s_out", 32'(so_w[0]), 32'd0);
      chk("rst_ready", 32'(rdy_w[0]), 32'd0);
      chk("rst_busy",  32'(busy_w[0]), 32'd0);
      chk("rst_done",  32'(done_w[0]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy_w[0]), 32'd1);

    // 2. 8'hA5 at one clock per bit
    send(0, 8'hA5, t1);
    seq = 10'b0101001011;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) valid_v[0] = 1'b0;
      if (k < 10) chk("a5_bit", 32'(so_w[0]), 32'(seq[k]));
      chk("a5_done", 32'(done_w[0]), 32'(k == 10));
    end

    // 3. 8'h01 at four clocks per bit
    send(1, 8'h01, t1);
    cnt = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) valid_v[1] = 1'b0;
      if (k < 40) chk("c4_bit", 32'(so_w[1]), 32'(k < 8));
      cnt += int'(busy_w[1]);
      chk("c4_done", 32'(done_w[1]), 32'(k == 40));
    end
    chk("c4_busy_len", 32'(cnt), 32'd40);

    // 4. back-to-back with in_valid held, data changed mid-frame
    send(0, 8'h3C, t1);
    got2 = 1'b0;
    t2   = 0;
    for (int k = 0; k < 20 && !got2; k++) begin
      @(negedge clk);
      if (k == 0) data_v[0] = 8'hC3;
      if (k < 10) fr[k] = so_w[0];
      if (rdy_w[0]) begin
        @(posedge clk);
        t2   = $time;
        got2 = 1'b1;
      end
    end
    chk("b2b_seen", 32'(got2), 32'd1);
    chk("b2b_spacing", 32'((t2 - t1) / 10), 32'd11);
    chk("f1_bits", 32'(fr), 32'h079);
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (12) @(negedge clk);

    // 5. reset during data bit 3 of 8'hFF
    send(0, 8'hFF, t1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) valid_v[0] = 1'b0;
      if (k == 4) begin
        chk("ff_bit3", 32'(so_w[0]), 32'd1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    chk("mid_rst_s_out", 32'(so_w[0]), 32'd0);
    chk("mid_rst_busy",  32'(busy_w[0]), 32'd0);
    chk("mid_rst_done",  32'(done_w[0]), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cnt += int'(done_w[0]);
    end
    chk("mid_rst_no_done", 32'(cnt), 32'd0);
    send(0, 8'h5A, t1);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) valid_v[0] = 1'b0;
      if (k == 1) chk("5a_bit0", 32'(so_w[0]), 32'd0);
      if (k == 2) chk("5a_bit1", 32'(so_w[0]), 32'd1);
      chk("5a_done", 32'(done_w[0]), 32'(k == 10));
    end

    // 6. WIDTH=4 into the SISO chain
    send(2, 8'h0B, t1);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) valid_v[2] = 1'b0;
      if (k == 5) chk("siso", 32'(siso), 32'hB);
    end
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
